// File: rtl/trace_frame_buffer_pkg.sv
// Shared types and widths for the trace frame buffer and its RAM.
package trace_frame_buffer_pkg;

  localparam int unsigned FRAME_W = 128;
  localparam int unsigned DROP_W  = 16;

  // One-hot prefetch states, same encoding style as the SPI packer.
  typedef enum logic [2:0] {
    ST_EMPTY = 3'b001,
    ST_FETCH = 3'b010,
    ST_VALID = 3'b100
  } pf_state_e;

endpackage

// File: rtl/frame_ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port (block-RAM style).
module frame_ram_sdp #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 128
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/trace_frame_buffer.sv
// FIFO of TPIU frames between the frame assembler and the SPI packer,
// with a show-ahead output register, occupancy count and overflow drop counter.
module trace_frame_buffer
  import trace_frame_buffer_pkg::*;
#(
  parameter int unsigned BUFFLENLOG2 = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FRAME_W-1:0]     FrameIn,
  input  logic                   FrameInValid,
  input  logic                   Flush,
  output logic [FRAME_W-1:0]     Frame,
  output logic                   FrameReady,
  input  logic                   FrameNext,
  output logic [BUFFLENLOG2-1:0] FramesCnt,
  output logic                   Full,
  output logic [DROP_W-1:0]      DroppedCnt
);

  localparam logic [BUFFLENLOG2-1:0] CAP = '1;

  pf_state_e               r_state;
  pf_state_e               w_state_nxt;
  logic [BUFFLENLOG2-1:0]  r_wptr;
  logic [BUFFLENLOG2-1:0]  r_rptr;
  logic [BUFFLENLOG2-1:0]  r_cnt;
  logic [DROP_W-1:0]       r_drop;
  logic [FRAME_W-1:0]      r_frame;
  logic                    r_rd_inflight;

  logic                    w_pop;
  logic                    w_wr;
  logic                    w_drop;
  logic                    w_rd;
  logic                    w_load;
  logic [FRAME_W-1:0]      w_ram_rdata;

  // Handshake decode; Flush overrides writes, pops, reads and loads.
  always_comb begin
    w_pop  = FrameNext && (r_state == ST_VALID);
    w_wr   = FrameInValid && !Flush && (!Full || w_pop);
    w_drop = FrameInValid && !Flush && Full && !w_pop;
    w_rd   = !Flush && (((r_state == ST_EMPTY) && (r_cnt != '0)) ||
                        ((r_state == ST_FETCH) && !r_rd_inflight));
    w_load = !Flush && (r_state == ST_FETCH) && r_rd_inflight;
  end

  // Prefetch next-state; FETCH waits until its RAM read has returned.
  always_comb begin
    w_state_nxt = r_state;
    if (Flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (r_cnt != '0) w_state_nxt = ST_FETCH;
        ST_FETCH: if (r_rd_inflight) w_state_nxt = ST_VALID;
        ST_VALID: begin
          if (w_pop) begin
            w_state_nxt = (r_cnt > BUFFLENLOG2'(1)) ? ST_FETCH : ST_EMPTY;
          end
        end
        default:  w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_EMPTY;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_cnt         <= '0;
      r_drop        <= '0;
      r_frame       <= '0;
      r_rd_inflight <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (Flush) begin
        // Equalising the pointers also discards any read already issued.
        r_rptr        <= r_wptr;
        r_cnt         <= '0;
        r_drop        <= '0;
        r_rd_inflight <= 1'b0;
      end else begin
        r_rd_inflight <= w_rd;
        if (w_wr) r_wptr <= r_wptr + BUFFLENLOG2'(1);
        if (w_rd) r_rptr <= r_rptr + BUFFLENLOG2'(1);
        if (w_wr && !w_pop) begin
          r_cnt <= r_cnt + BUFFLENLOG2'(1);
        end else if (!w_wr && w_pop) begin
          r_cnt <= r_cnt - BUFFLENLOG2'(1);
        end
        if (w_drop && (r_drop != '1)) r_drop <= r_drop + DROP_W'(1);
        if (w_load) r_frame <= w_ram_rdata;
      end
    end
  end

  frame_ram_sdp #(
    .AW (BUFFLENLOG2),
    .DW (FRAME_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (r_wptr),
    .i_wdata (FrameIn),
    .i_re    (w_rd),
    .i_raddr (r_rptr),
    .o_rdata (w_ram_rdata)
  );

  assign Frame      = r_frame;
  // VALID bit of the one-hot state register.
  assign FrameReady = r_state[2];
  assign FramesCnt  = r_cnt;
  assign Full       = (r_cnt == CAP);
  assign DroppedCnt = r_drop;

endmodule

// File: tb/tb_trace_frame_buffer.sv
// Scoreboard bench for trace_frame_buffer with an 8-deep RAM (capacity 7).
module tb_trace_frame_buffer;

  logic         clk;
  logic         rst;
  logic [127:0] FrameIn;
  logic         FrameInValid;
  logic         Flush;
  logic [127:0] Frame;
  logic         FrameReady;
  logic         FrameNext;
  logic [2:0]   FramesCnt;
  logic         Full;
  logic [15:0]  DroppedCnt;

  int total = 0;
  int bad   = 0;
  logic [127:0] exp_q [$];
  logic prev_rdy = 1'b0;

  trace_frame_buffer #(.BUFFLENLOG2(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .FrameIn      (FrameIn),
    .FrameInValid (FrameInValid),
    .Flush        (Flush),
    .Frame        (Frame),
    .FrameReady   (FrameReady),
    .FrameNext    (FrameNext),
    .FramesCnt    (FramesCnt),
    .Full         (Full),
    .DroppedCnt   (DroppedCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: each newly presented frame must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      prev_rdy = 1'b0;
    end else begin
      if (FrameReady && !prev_rdy) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got %0h expected none", Frame);
        end else begin
          logic [127:0] e;
          e = exp_q.pop_front();
          if (Frame !== e) begin
            bad++;
            $display("FAIL sb_order: got %0h expected %0h", Frame, e);
          end
        end
      end
      prev_rdy = FrameReady;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [127:0] d, input bit accept);
    FrameIn = d;
    FrameInValid = 1'b1;
    if (accept) exp_q.push_back(d);
    cyc(1);
    FrameInValid = 1'b0;
  endtask

  task automatic pop();
    FrameNext = 1'b1;
    cyc(1);
    FrameNext = 1'b0;
  endtask

  task automatic wait_ready(input string nm, output int n);
    n = 0;
    while (!FrameReady && n < 20) begin
      cyc(1);
      n++;
    end
    if (!FrameReady) begin
      total++;
      bad++;
      $display("FAIL %s: got timeout expected FrameReady", nm);
    end
  endtask

  initial begin
    int n;
    int sent;
    rst = 1'b1;
    FrameIn = '0;
    FrameInValid = 1'b0;
    Flush = 1'b0;
    FrameNext = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(10);

    // Reset / idle
    chk("rst_ready", 128'(FrameReady), 128'd0);
    chk("rst_cnt",   128'(FramesCnt),  128'd0);
    chk("rst_drop",  128'(DroppedCnt), 128'd0);
    chk("rst_full",  128'(Full),       128'd0);
    chk("rst_frame", Frame,            128'd0);

    // Single frame: ready two edges after the write edge
    wr(128'h1, 1'b1);
    chk("s_cnt_e0",   128'(FramesCnt),  128'd1);
    chk("s_ready_e0", 128'(FrameReady), 128'd0);
    cyc(1);
    chk("s_ready_e1", 128'(FrameReady), 128'd0);
    cyc(1);
    chk("s_ready_e2", 128'(FrameReady), 128'd1);
    chk("s_frame",    Frame,            128'h1);
    pop();
    chk("s_ready_pop", 128'(FrameReady), 128'd0);
    chk("s_cnt_pop",   128'(FramesCnt),  128'd0);

    // Three back-to-back frames, popped as they appear
    wr(128'h1, 1'b1);
    wr(128'h2, 1'b1);
    wr(128'h3, 1'b1);
    for (int k = 0; k < 3; k++) begin
      wait_ready("b3_wait", n);
      if (k > 0) chk("b3_pop_to_ready", 128'(n), 128'd2);
      chk("b3_cnt_before", 128'(FramesCnt), 128'(3 - k));
      pop();
      chk("b3_cnt_after", 128'(FramesCnt), 128'(2 - k));
    end

    // Overflow: 9 writes into capacity 7
    FrameInValid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      FrameIn = 128'(256 + i);
      if (i < 7) exp_q.push_back(FrameIn);
      cyc(1);
      chk("ov_full", 128'(Full), (i >= 6) ? 128'd1 : 128'd0);
    end
    FrameInValid = 1'b0;
    chk("ov_cnt",  128'(FramesCnt),  128'd7);
    chk("ov_drop", 128'(DroppedCnt), 128'd2);
    chk("ov_ready", 128'(FrameReady), 128'd1);
    // Pop and write in the same cycle while full
    FrameNext = 1'b1;
    FrameInValid = 1'b1;
    FrameIn = 128'h1FF;
    exp_q.push_back(128'h1FF);
    cyc(1);
    FrameNext = 1'b0;
    FrameInValid = 1'b0;
    chk("ov_pw_cnt",  128'(FramesCnt),  128'd7);
    chk("ov_pw_drop", 128'(DroppedCnt), 128'd2);
    chk("ov_pw_full", 128'(Full),       128'd1);
    for (int k = 0; k < 7; k++) begin
      wait_ready("ov_drain_wait", n);
      pop();
    end
    chk("ov_drained_cnt", 128'(FramesCnt), 128'd0);

    // Wrap-around stream of 40 frames with interleaved pops
    sent = 0;
    for (int c = 0; c < 600 && (sent < 40 || FramesCnt != 3'd0 || FrameReady); c++) begin
      FrameNext = FrameReady;
      if (sent < 40 && FramesCnt < 3'd7 && (c % 2 == 0)) begin
        FrameIn = 128'(512 + sent);
        FrameInValid = 1'b1;
        exp_q.push_back(FrameIn);
        sent++;
      end else begin
        FrameInValid = 1'b0;
      end
      cyc(1);
    end
    FrameNext = 1'b0;
    FrameInValid = 1'b0;
    cyc(1);
    chk("wrap_sent",    128'(sent),         128'd40);
    chk("wrap_drained", 128'(exp_q.size()), 128'd0);
    chk("wrap_cnt",     128'(FramesCnt),    128'd0);
    chk("wrap_drop",    128'(DroppedCnt),   128'd2);

    // Flush with 5 frames held and a concurrent write
    for (int i = 0; i < 5; i++) wr(128'(768 + i), 1'b1);
    chk("fl_cnt_before",  128'(FramesCnt),  128'd5);
    chk("fl_drop_before", 128'(DroppedCnt), 128'd2);
    Flush = 1'b1;
    FrameInValid = 1'b1;
    FrameIn = 128'h3FF;
    cyc(1);
    Flush = 1'b0;
    FrameInValid = 1'b0;
    exp_q.delete();
    chk("fl_cnt",   128'(FramesCnt),  128'd0);
    chk("fl_ready", 128'(FrameReady), 128'd0);
    chk("fl_drop",  128'(DroppedCnt), 128'd0);
    chk("fl_full",  128'(Full),       128'd0);
    wr(128'h400, 1'b1);
    chk("fl_w_ready_e0", 128'(FrameReady), 128'd0);
    cyc(1);
    chk("fl_w_ready_e1", 128'(FrameReady), 128'd0);
    cyc(1);
    chk("fl_w_ready_e2", 128'(FrameReady), 128'd1);
    chk("fl_w_frame",    Frame,            128'h400);
    pop();

    // FrameNext while not ready is ignored
    wr(128'h500, 1'b1);
    pop();
    chk("nr_cnt_fetch",   128'(FramesCnt),  128'd1);
    chk("nr_ready_fetch", 128'(FrameReady), 128'd0);
    cyc(1);
    chk("nr_ready", 128'(FrameReady), 128'd1);
    chk("nr_frame", Frame,            128'h500);
    pop();
    chk("nr_cnt_pop", 128'(FramesCnt), 128'd0);
    pop();
    chk("nr_cnt_empty", 128'(FramesCnt), 128'd0);
    cyc(2);
    chk("nr_ready_empty", 128'(FrameReady), 128'd0);
    wr(128'h501, 1'b1);
    wait_ready("nr_next_wait", n);
    chk("nr_next_frame", Frame, 128'h501);
    pop();

    // Async reset while a fetch is in flight
    wr(128'h600, 1'b0);
    cyc(1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_ready", 128'(FrameReady), 128'd0);
    chk("ar_cnt",   128'(FramesCnt),  128'd0);
    chk("ar_frame", Frame,            128'd0);
    chk("ar_drop",  128'(DroppedCnt), 128'd0);
    chk("ar_full",  128'(Full),       128'd0);
    cyc(1);
    rst = 1'b0;
    cyc(4);
    chk("ar_after_ready", 128'(FrameReady), 128'd0);
    chk("ar_after_cnt",   128'(FramesCnt),  128'd0);

    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
